reconstruct_l6: RTL and testbench

Level-6 approximation-only inverse-DWT stage of the Sym4 baseline extractor. It sits directly downstream of reconstruct_L7 and consumes its r6 stream. It upsamples r6 by 2 and applies the 8-tap Sym4 reconstruction low-pass in polyphase form, producing the r5 stream for the next reconstruction level. Detail coefficients are treated as zero, because only the baseline is rebuilt.

---
 rtl/wavelet_pkg.sv | 43 ++++
 rtl/wavelet_round_sat.sv | 27 ++
 rtl/reconstruct_l6.sv | 151 +++++++++++++++
 tb/tb_reconstruct_l6.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared Sym4 wavelet constants and fixed-point helpers for the decompose and
// reconstruct levels of the baseline extractor.
package wavelet_pkg;

  localparam int DEF_INTERNAL_WIDTH = 48;
  localparam int DEF_COEF_WIDTH     = 25;
  localparam int DEF_COEF_FRAC      = 23;
  localparam int WIDE_W             = 128;

  typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

  // Sym4 decomposition low-pass taps in Q1.23.
  localparam coef_t SYM4_DEC_H0 = -25'sd635569;
  localparam coef_t SYM4_DEC_H1 = -25'sd248601;
  localparam coef_t SYM4_DEC_H2 =  25'sd4174328;
  localparam coef_t SYM4_DEC_H3 =  25'sd6742249;
  localparam coef_t SYM4_DEC_H4 =  25'sd2498612;
  localparam coef_t SYM4_DEC_H5 = -25'sd832314;
  localparam coef_t SYM4_DEC_H6 = -25'sd105730;
  localparam coef_t SYM4_DEC_H7 =  25'sd270307;

  // Reconstruction low-pass is the time-reversed decomposition low-pass.
  localparam coef_t SYM4_REC_H0 = SYM4_DEC_H7;
  localparam coef_t SYM4_REC_H1 = SYM4_DEC_H6;
  localparam coef_t SYM4_REC_H2 = SYM4_DEC_H5;
  localparam coef_t SYM4_REC_H3 = SYM4_DEC_H4;
  localparam coef_t SYM4_REC_H4 = SYM4_DEC_H3;
  localparam coef_t SYM4_REC_H5 = SYM4_DEC_H2;
  localparam coef_t SYM4_REC_H6 = SYM4_DEC_H1;
  localparam coef_t SYM4_REC_H7 = SYM4_DEC_H0;

  // Round half up, then arithmetic shift right by frac.
  function automatic logic signed [WIDE_W-1:0] round_shift(
    input logic signed [WIDE_W-1:0] v,
    input int                       frac
  );
    logic signed [WIDE_W-1:0] half;
    half = '0;
    if (frac > 0) half[frac-1] = 1'b1;
    return (v + half) >>> frac;
  endfunction

endpackage

// File: rtl/wavelet_round_sat.sv
// Combinational round-half-up and saturate from a wide fixed-point sum down to
// the internal sample width.
module wavelet_round_sat
  import wavelet_pkg::*;
#(
  parameter int IN_W  = 75,
  parameter int OUT_W = 48,
  parameter int FRAC  = 23
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [WIDE_W-1:0] MAX_V = (WIDE_W'(1) <<< (OUT_W-1)) - WIDE_W'(1);
  localparam logic signed [WIDE_W-1:0] MIN_V = -(WIDE_W'(1) <<< (OUT_W-1));

  logic signed [WIDE_W-1:0] shifted;

  // NOTE: every path assigns dout, so this stays purely combinational (no latch).
  always_comb begin
    shifted = round_shift(WIDE_W'(din), FRAC);
    if (shifted > MAX_V)      dout = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) dout = MIN_V[OUT_W-1:0];
    else                      dout = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/reconstruct_l6.sv
// Level-6 approximation-only inverse DWT: upsample r6 by 2 and apply the Sym4
// reconstruction low-pass in polyphase form, emitting even then odd r5 samples.
module reconstruct_l6
  import wavelet_pkg::*;
#(
  parameter int INTERNAL_WIDTH = DEF_INTERNAL_WIDTH,
  parameter int COEF_WIDTH     = DEF_COEF_WIDTH,
  parameter int COEF_FRAC      = DEF_COEF_FRAC,
  parameter logic signed [COEF_WIDTH-1:0] REC_H0 = COEF_WIDTH'(SYM4_REC_H0),
  parameter logic signed [COEF_WIDTH-1:0] REC_H1 = COEF_WIDTH'(SYM4_REC_H1),
  parameter logic signed [COEF_WIDTH-1:0] REC_H2 = COEF_WIDTH'(SYM4_REC_H2),
  parameter logic signed [COEF_WIDTH-1:0] REC_H3 = COEF_WIDTH'(SYM4_REC_H3),
  parameter logic signed [COEF_WIDTH-1:0] REC_H4 = COEF_WIDTH'(SYM4_REC_H4),
  parameter logic signed [COEF_WIDTH-1:0] REC_H5 = COEF_WIDTH'(SYM4_REC_H5),
  parameter logic signed [COEF_WIDTH-1:0] REC_H6 = COEF_WIDTH'(SYM4_REC_H6),
  parameter logic signed [COEF_WIDTH-1:0] REC_H7 = COEF_WIDTH'(SYM4_REC_H7)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             din_valid,
  input  logic signed [INTERNAL_WIDTH-1:0] r6_in,
  output logic                             dout_valid,
  output logic signed [INTERNAL_WIDTH-1:0] r5_out,
  output logic                             overrun
);

  localparam int PROD_W = INTERNAL_WIDTH + COEF_WIDTH;
  localparam int SUM_W  = PROD_W + 2;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_ODD_PEND = 1'b1;

  // Even taps pair with x[i] at index 2*i, odd taps at 2*i+1.
  localparam logic signed [COEF_WIDTH-1:0] H [8] =
    '{REC_H0, REC_H1, REC_H2, REC_H3, REC_H4, REC_H5, REC_H6, REC_H7};

  logic                             accept;
  logic                             lockout_q, lockout_d;
  logic                             overrun_q, overrun_d;
  logic                             hist_vld_q, hist_vld_d;
  logic signed [INTERNAL_WIDTH-1:0] x_q [4];
  logic signed [INTERNAL_WIDTH-1:0] x_d [4];
  logic                             prod_vld_q, prod_vld_d;
  logic signed [PROD_W-1:0]         prod_q [8];
  logic signed [PROD_W-1:0]         prod_d [8];
  logic                             sum_vld_q, sum_vld_d;
  logic signed [SUM_W-1:0]          sum_even_q, sum_even_d;
  logic signed [SUM_W-1:0]          sum_odd_q, sum_odd_d;
  logic signed [INTERNAL_WIDTH-1:0] even_rs, odd_rs;
  logic signed [INTERNAL_WIDTH-1:0] odd_hold_q, odd_hold_d;
  logic [0:0]                       state_q, state_d;
  logic                             dout_valid_q, dout_valid_d;
  logic signed [INTERNAL_WIDTH-1:0] r5_out_q, r5_out_d;

  always_comb begin
    accept     = din_valid && !lockout_q;
    lockout_d  = accept;
    overrun_d  = overrun_q || (din_valid && lockout_q);
    hist_vld_d = accept;
    x_d        = x_q;
    if (accept) begin
      x_d[0] = r6_in;
      for (int i = 1; i < 4; i++) x_d[i] = x_q[i-1];
    end
  end

  always_comb begin
    prod_vld_d = hist_vld_q;
    prod_d     = prod_q;
    if (hist_vld_q) begin
      for (int j = 0; j < 8; j++) prod_d[j] = PROD_W'(H[j]) * PROD_W'(x_q[j/2]);
    end
  end

  always_comb begin
    sum_vld_d  = prod_vld_q;
    sum_even_d = sum_even_q;
    sum_odd_d  = sum_odd_q;
    if (prod_vld_q) begin
      sum_even_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[2]) + SUM_W'(prod_q[4]) + SUM_W'(prod_q[6]);
      sum_odd_d  = SUM_W'(prod_q[1]) + SUM_W'(prod_q[3]) + SUM_W'(prod_q[5]) + SUM_W'(prod_q[7]);
    end
  end

  wavelet_round_sat #(.IN_W(SUM_W), .OUT_W(INTERNAL_WIDTH), .FRAC(COEF_FRAC)) u_rs_even (
    .din  (sum_even_q),
    .dout (even_rs)
  );

  wavelet_round_sat #(.IN_W(SUM_W), .OUT_W(INTERNAL_WIDTH), .FRAC(COEF_FRAC)) u_rs_odd (
    .din  (sum_odd_q),
    .dout (odd_rs)
  );

  // Input spacing of >= 2 cycles keeps a new even result off a pending odd slot.
  always_comb begin
    state_d      = state_q;
    odd_hold_d   = odd_hold_q;
    dout_valid_d = 1'b0;
    r5_out_d     = r5_out_q;
    if (sum_vld_q) begin
      dout_valid_d = 1'b1;
      r5_out_d     = even_rs;
      odd_hold_d   = odd_rs;
      state_d      = ST_ODD_PEND;
    end else if (state_q == ST_ODD_PEND) begin
      dout_valid_d = 1'b1;
      r5_out_d     = odd_hold_q;
      state_d      = ST_IDLE;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      hist_vld_q   <= 1'b0;
      prod_vld_q   <= 1'b0;
      sum_vld_q    <= 1'b0;
      sum_even_q   <= '0;
      sum_odd_q    <= '0;
      odd_hold_q   <= '0;
      state_q      <= ST_IDLE;
      dout_valid_q <= 1'b0;
      r5_out_q     <= '0;
      // NOTE: history and products are small register arrays, not RAM, so they reset.
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
      for (int j = 0; j < 8; j++) prod_q[j] <= '0;
    end else begin
      lockout_q    <= lockout_d;
      overrun_q    <= overrun_d;
      hist_vld_q   <= hist_vld_d;
      prod_vld_q   <= prod_vld_d;
      sum_vld_q    <= sum_vld_d;
      sum_even_q   <= sum_even_d;
      sum_odd_q    <= sum_odd_d;
      odd_hold_q   <= odd_hold_d;
      state_q      <= state_d;
      dout_valid_q <= dout_valid_d;
      r5_out_q     <= r5_out_d;
      x_q          <= x_d;
      prod_q       <= prod_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign r5_out     = r5_out_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_reconstruct_l6.sv
// Self-checking bench for reconstruct_l6: impulse/DC vector tables plus
// saturation, spacing-violation, mid-operation reset and full-rate sequences.
module tb_reconstruct_l6;

  localparam int W = 48;
  localparam longint H [8] =
    '{270307, -105730, -832314, 2498612, 6742249, 4174328, -248601, -635569};
  localparam longint ONE_Q23 = 64'sd8388608;
  localparam longint MAX_V   = 64'sd140737488355327;
  localparam longint MIN_V   = -64'sd140737488355328;

  typedef struct {
    longint din;
    longint exp_even;
    longint exp_odd;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                din_valid;
  logic signed [W-1:0] r6_in;
  logic                dout_valid, overrun;
  logic signed [W-1:0] r5_out;
  logic                sat_valid, sat_overrun;
  logic signed [W-1:0] sat_out;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint out_q[$];
  longint out_cyc[$];
  longint sat_q[$];
  vec_t   vecs [5];

  reconstruct_l6 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .r6_in      (r6_in),
    .dout_valid (dout_valid),
    .r5_out     (r5_out),
    .overrun    (overrun)
  );

  reconstruct_l6 #(
    .REC_H0(25'sh0FFFFFF), .REC_H1(25'sd0), .REC_H2(25'sd0), .REC_H3(25'sd0),
    .REC_H4(25'sd0), .REC_H5(25'sd0), .REC_H6(25'sd0), .REC_H7(25'sd0)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .r6_in      (r6_in),
    .dout_valid (sat_valid),
    .r5_out     (sat_out),
    .overrun    (sat_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid) begin
      out_q.push_back(longint'(r5_out));
      out_cyc.push_back(cyc);
    end
    if (sat_valid) sat_q.push_back(longint'(sat_out));
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    longint diff;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic expect_pop(input string name, input longint exp, input bit from_sat);
    if ((from_sat ? sat_q.size() : out_q.size()) == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no output expected %0d", name, exp);
    end else if (from_sat) begin
      check(name, sat_q.pop_front(), exp);
    end else begin
      check(name, out_q.pop_front(), exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    out_q.delete();
    out_cyc.delete();
    sat_q.delete();
  endtask

  task automatic send(input longint v, input int idle);
    din_valid = 1'b1;
    r6_in     = v[W-1:0];
    @(posedge clk);
    #1;
    last_acc  = cyc;
    din_valid = 1'b0;
    tick(idle);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rst_n     = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_queues();
  endtask

  task automatic run_impulse(input string tag);
    longint first_acc;
    first_acc = 0;
    clear_queues();
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din, 3);
      if (i == 0) first_acc = last_acc;
    end
    tick(4);
    check($sformatf("%s_count", tag), out_q.size(), 10);
    check($sformatf("%s_latency", tag),
          (out_cyc.size() > 0) ? out_cyc[0] - first_acc : -1, 3);
    check($sformatf("%s_pair_gap", tag),
          (out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1, 1);
    for (int i = 0; i < 5; i++) begin
      expect_pop($sformatf("%s_even%0d", tag, i), vecs[i].exp_even, 1'b0);
      expect_pop($sformatf("%s_odd%0d", tag, i), vecs[i].exp_odd, 1'b0);
    end
  endtask

  initial begin
    longint hist [4];
    longint exp_q[$];
    longint v, acc_e, acc_o;

    vecs[0] = '{ONE_Q23, H[0], H[1]};
    vecs[1] = '{0, H[2], H[3]};
    vecs[2] = '{0, H[4], H[5]};
    vecs[3] = '{0, H[6], H[7]};
    vecs[4] = '{0, 0, 0};

    // Reset state
    din_valid = 1'b0;
    r6_in     = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check("rst_dout_valid", longint'(dout_valid), 0);
    check("rst_r5_out", longint'(r5_out), 0);
    check("rst_overrun", longint'(overrun), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // Impulse: output is the reconstruction filter itself
    run_impulse("imp");

    // DC gain: both polyphase branches sum to ~0.7071
    do_reset();
    for (int i = 0; i < 40; i++) send(1000, 3);
    tick(4);
    check("dc_count", out_q.size(), 80);
    for (int i = 6; i < 80; i++) begin
      if (i < out_q.size()) check_tol($sformatf("dc_out%0d", i), out_q[i], 707, 1);
    end

    // Saturation with an oversized H0
    do_reset();
    send(MAX_V, 3);
    send(MIN_V, 3);
    tick(4);
    check("sat_count", sat_q.size(), 4);
    expect_pop("sat_even_pos", MAX_V, 1'b1);
    expect_pop("sat_odd_pos", 0, 1'b1);
    expect_pop("sat_even_neg", MIN_V, 1'b1);
    expect_pop("sat_odd_neg", 0, 1'b1);

    // Spacing violation: A accepted, B dropped
    do_reset();
    din_valid = 1'b1;
    r6_in     = ONE_Q23[W-1:0];
    tick(1);
    r6_in     = W'(5 * ONE_Q23);
    tick(1);
    din_valid = 1'b0;
    tick(6);
    check("ovr_flag", longint'(overrun), 1);
    check("ovr_count", out_q.size(), 2);
    expect_pop("ovr_even_a", H[0], 1'b0);
    expect_pop("ovr_odd_a", H[1], 1'b0);
    send(0, 3);
    tick(4);
    expect_pop("ovr_even_next", H[2], 1'b0);
    expect_pop("ovr_odd_next", H[3], 1'b0);
    check("ovr_sticky", longint'(overrun), 1);
    check("ovr_no_extra", out_q.size(), 0);

    // Reset one cycle after acceptance; overrun and r5_out are non-zero here
    clear_queues();
    send(ONE_Q23, 0);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_dout_valid", longint'(dout_valid), 0);
    check("midrst_r5_out", longint'(r5_out), 0);
    check("midrst_overrun", longint'(overrun), 0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    check("midrst_no_stale", out_q.size(), 0);
    run_impulse("post_rst");

    // Back-to-back at the minimum legal spacing against a 64-bit model
    do_reset();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    for (int i = 0; i < 20; i++) begin
      v = longint'($urandom_range(0, 32'h7FFF_FFFF)) - 64'sd1073741824;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
      acc_e = 0;
      acc_o = 0;
      for (int k = 0; k < 4; k++) begin
        acc_e += H[2*k] * hist[k];
        acc_o += H[2*k+1] * hist[k];
      end
      exp_q.push_back((acc_e + 64'sd4194304) >>> 23);
      exp_q.push_back((acc_o + 64'sd4194304) >>> 23);
      send(v, 1);
    end
    tick(6);
    check("b2b_count", out_q.size(), 40);
    check("b2b_span", (out_cyc.size() > 0) ? out_cyc[out_cyc.size()-1] - out_cyc[0] : -1, 39);
    check("b2b_overrun", longint'(overrun), 0);
    for (int i = 0; i < 40; i++) expect_pop($sformatf("b2b_out%0d", i), exp_q[i], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
